// File: rtl/wacboard_spi_pkg.sv
// ============================================================================
// Module      : wacboard_spi_pkg
// Description : Shared definitions for the board SPI master: FSM state
//               encoding, SPI mode constants and default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wacboard_spi_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Default sizing
    localparam int DEF_MAX_BITS = 16;
    localparam int DEF_DIV_W    = 8;

endpackage : wacboard_spi_pkg

`default_nettype wire

// File: rtl/spi_halfper_tick.sv
// ============================================================================
// Module      : spi_halfper_tick
// Description : Loadable down-counter producing one tick every (val_i+1)
//               enabled cycles. Held loaded while disabled so that the first
//               half-period after enable is exact.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_halfper_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] val_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == '0);

    // Count down while enabled; reload on every tick and whenever held loaded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i || tick_o) begin
            cnt_q <= val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

endmodule : spi_halfper_tick

`default_nettype wire

// File: rtl/spi_multi_master.sv
// ============================================================================
// Module      : spi_multi_master
// Description : Single SPI shift engine shared by N_CS chip selects, with
//               per-transfer word length, SPI mode and SCLK divider, and
//               MISO capture for ADC read-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_multi_master
    import wacboard_spi_pkg::*;
#(
    parameter int N_CS     = 4,
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [((N_CS > 1) ? $clog2(N_CS) : 1)-1:0] cs_sel,
    input  logic [$clog2(MAX_BITS+1)-1:0]          nbits,
    input  logic [DIV_W-1:0]                       div,
    input  logic                                   cpol,
    input  logic                                   cpha,
    input  logic [MAX_BITS-1:0]                    tx_data,
    output logic                                   busy,
    output logic                                   done,
    output logic [MAX_BITS-1:0]                    rx_data,
    output logic                                   sclk,
    output logic                                   mosi,
    input  logic                                   miso,
    output logic [N_CS-1:0]                        cs_n
);

    localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int NB_W = $clog2(MAX_BITS + 1);
    localparam int HP_W = NB_W + 1;
    localparam logic [NB_W-1:0] NB_MAX = NB_W'(MAX_BITS);

    spi_state_e          state_q;
    logic                cpha_q;
    logic [NB_W-1:0]     n_q;
    logic [DIV_W-1:0]    div_q;
    logic [HP_W-1:0]     half_q;
    logic [MAX_BITS-1:0] tx_sh_q;
    logic [MAX_BITS-1:0] rx_sh_q;
    logic [MAX_BITS-1:0] rx_data_q;
    logic                sclk_q;
    logic                mosi_q;
    logic [N_CS-1:0]     cs_n_q;
    logic                busy_q;
    logic                done_q;

    logic                w_sel_ok;
    logic                w_tick;
    logic [DIV_W-1:0]    w_tick_val;
    logic [NB_W-1:0]     w_nb_eff;
    logic [NB_W-1:0]     w_align_sh;
    logic [MAX_BITS-1:0] w_tx_align;
    logic [N_CS-1:0]     w_cs_dec;
    logic                w_lead;
    logic                w_last_half;
    logic                w_sample;
    logic                w_update;

    // Only non-power-of-two chip-select counts can see an out-of-range select
    generate
        if ((1 << CS_W) > N_CS) begin : g_sel_chk
            localparam logic [CS_W:0] N_CS_V = (CS_W + 1)'(N_CS);
            assign w_sel_ok = ({1'b0, cs_sel} < N_CS_V);
        end else begin : g_sel_all
            assign w_sel_ok = 1'b1;
        end
    endgenerate

    // Word length 0 or oversize falls back to the full register width
    assign w_nb_eff   = ((nbits == '0) || (nbits > NB_MAX)) ? NB_MAX : nbits;
    // Left-align the word so the current bit is always the register MSB
    assign w_align_sh = NB_MAX - w_nb_eff;
    assign w_tx_align = tx_data << w_align_sh;

    // Decode the requested chip select into an active-low one-cold vector
    always_comb begin
        w_cs_dec         = '1;
        w_cs_dec[cs_sel] = 1'b0;
    end

    // Divider follows the live input in IDLE so the first half-period is exact
    assign w_tick_val = (state_q == ST_IDLE) ? div : div_q;

    spi_halfper_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == ST_IDLE),
        .en_i   (state_q != ST_IDLE),
        .val_i  (w_tick_val),
        .tick_o (w_tick)
    );

    // Even half-period index in SHIFT ends on a leading SCLK edge
    assign w_lead      = ~half_q[0];
    assign w_last_half = (half_q == ({n_q, 1'b0} - HP_W'(1)));
    assign w_sample    = w_lead ^ cpha_q;
    // CPHA=1 keeps the MSB placed in SETUP through the first leading edge;
    // CPHA=0 has nothing left to shift out after the final trailing edge
    assign w_update    = cpha_q ? (w_lead && (half_q != '0))
                                : (!w_lead && !w_last_half);

    // Transfer sequencer with registered pin and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cpha_q    <= 1'b0;
            n_q       <= '0;
            div_q     <= '0;
            half_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start && w_sel_ok) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        cs_n_q  <= w_cs_dec;
                        sclk_q  <= cpol;
                        cpha_q  <= cpha;
                        n_q     <= w_nb_eff;
                        div_q   <= div;
                        tx_sh_q <= w_tx_align;
                        mosi_q  <= w_tx_align[MAX_BITS-1];
                        rx_sh_q <= '0;
                        half_q  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        sclk_q <= ~sclk_q;
                        half_q <= half_q + HP_W'(1);
                        if (w_sample) begin
                            rx_sh_q <= {rx_sh_q[MAX_BITS-2:0], miso};
                        end
                        if (w_update) begin
                            tx_sh_q <= tx_sh_q << 1;
                            mosi_q  <= tx_sh_q[MAX_BITS-2];
                        end
                        if (w_last_half) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        state_q <= ST_GAP;
                        cs_n_q  <= '1;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule : spi_multi_master

`default_nettype wire
